arm_multicycle_ctrl: RTL and testbench

//  Control unit for the multicycle ARM-subset datapath; sits directly upstream of the alu.

---
 rtl/arm_multicycle_ctrl_if.sv | 34 +++
 rtl/arm_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction fields and ALU flags into the multicycle ARM controller,
// plus the datapath selects and write enables it drives back out.
interface arm_multicycle_ctrl_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;

    logic [1:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Flags
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  ALUControl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
               AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Flags
    );
endinterface

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM-subset control unit: main FSM, ALU decoder and NZCV condition logic.
// Define COND_EXEC_EN to honour the Cond field; otherwise every instruction executes.
module arm_multicycle_ctrl #(
    parameter logic [3:0] PC_REG      = 4'd15,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                   clk,
    input  logic                   reset,
    arm_multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic       alu_op;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;

    logic [1:0] alu_control;
    logic [1:0] flag_w;
    logic       no_write;
    logic       cond_ex;
    logic       pcs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= RESET_FLAGS;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore decode; unlisted selects default to zero, which also covers unused encodings.
    always_comb begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        alu_op     = 1'b0;
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = 1'b1;
                next_pc    = 1'b1;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR:  alu_op = 1'b1;
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
            end
            S_ALUWB:  reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // Unrecognised commands fall back to ADD with no flag update, even when S is set.
    always_comb begin
        alu_control = 2'b00;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: begin
                    alu_control = 2'b00;
                    flag_w      = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0010: begin
                    alu_control = 2'b01;
                    flag_w      = {bus.Funct[0], bus.Funct[0]};
                end
                4'b0000: begin
                    alu_control = 2'b10;
                    flag_w      = {bus.Funct[0], 1'b0};
                end
                4'b1100: begin
                    alu_control = 2'b11;
                    flag_w      = {bus.Funct[0], 1'b0};
                end
                4'b1010: begin
                    alu_control = 2'b01;
                    flag_w      = 2'b11;
                end
                default: begin
                    alu_control = 2'b00;
                    flag_w      = 2'b00;
                end
            endcase
        end
    end

    // CMP only suppresses the writeback of data-processing instructions, not loads.
    assign no_write = (bus.Op == 2'b00) && (bus.Funct[4:1] == 4'b1010);

`ifdef COND_EXEC_EN
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^bus.Cond;
    assign cond_ex     = 1'b1;
`endif

    // Flags are captured on the edge leaving an execute state, so the next instruction sees them.
    always_comb begin
        flags_d = flags_q;
        if (((state_q == S_EXECR) || (state_q == S_EXECI)) && cond_ex) begin
            if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    assign pcs = (reg_w && (bus.Rd == PC_REG)) || branch;

    // Write enables are forced low for as long as reset is held, independent of state.
    assign bus.IRWrite  = reset & ir_write;
    assign bus.PCWrite  = reset & (next_pc | (pcs & cond_ex));
    assign bus.RegWrite = reset & reg_w & cond_ex & ~no_write;
    assign bus.MemWrite = reset & mem_w & cond_ex;

    assign bus.ALUControl = alu_control;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.AdrSrc     = adr_src;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.Flags      = flags_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: instruction-level reference model,
// directed scenarios plus randomized instruction streams.
module tb_arm_multicycle_ctrl;

`ifdef COND_EXEC_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic       adr;
        logic       ir;
        logic       pc;
        logic       rw;
        logic       mw;
        logic [3:0] flags;
        logic [1:0] imm;
        logic [1:0] rsrc;
    } out_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [3:0] m_flags;

    arm_multicycle_ctrl_if bus();

    arm_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Architectural condition evaluation on NZCV.
    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v;
        {n, z, cy, v} = fl;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {alu control, flag write mask} for a data-processing Funct field.
    function automatic logic [3:0] model_alu(input logic [5:0] f);
        logic [1:0] ctl;
        logic [1:0] fw;
        bit known;
        known = 1'b1;
        ctl   = 2'd0;
        case (f[4:1])
            4'b0100: ctl = 2'd0;
            4'b0010: ctl = 2'd1;
            4'b0000: ctl = 2'd2;
            4'b1100: ctl = 2'd3;
            4'b1010: ctl = 2'd1;
            default: known = 1'b0;
        endcase
        if (!known)                fw = 2'b00;
        else if (f[4:1] == 4'b1010) fw = 2'b11;
        else                       fw = {f[0], f[0] && (ctl < 2'd2)};
        return {ctl, fw};
    endfunction

    // Drives one instruction from its FETCH cycle onward and checks every cycle against the model.
    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
        string ph[$];
        out_t  e, m, o;
        logic [3:0] dec;
        bit cex, regw, nowr;
        bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
        ph = '{"FETCH", "DECODE"};
        case (op)
            2'b01: begin
                ph.push_back("MEMADR");
                if (f[0]) begin ph.push_back("MEMRD"); ph.push_back("MEMWB"); end
                else ph.push_back("MEMWR");
            end
            2'b00: begin
                ph.push_back(f[5] ? "EXECI" : "EXECR");
                ph.push_back("ALUWB");
            end
            2'b10: ph.push_back("BRANCH");
            default: ;
        endcase
        dec  = model_alu(f);
        nowr = (op == 2'b00) && (f[4:1] == 4'b1010);
        foreach (ph[i]) begin
            @(negedge clk);
            cex = !COND_EN || cond_ok(c, m_flags);
            e = '0;
            m = '0;
            m.ir = 1'b1; m.pc = 1'b1; m.rw = 1'b1; m.mw = 1'b1;
            m.flags = 4'hf; m.imm = 2'b11; m.rsrc = 2'b11;
            e.flags = m_flags;
            e.imm   = op;
            e.rsrc  = {op == 2'b01, op == 2'b10};
            case (ph[i])
                "FETCH", "DECODE": begin
                    e.src_a = 1'b1; e.src_b = 2'b10; e.res = 2'b10;
                    m.src_a = 1'b1; m.src_b = 2'b11; m.res = 2'b11; m.alu = 2'b11;
                    if (ph[i] == "FETCH") m.adr = 1'b1;
                end
                "MEMADR": begin
                    e.src_b = 2'b01;
                    m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 2'b11;
                end
                "MEMRD", "MEMWR": begin
                    e.adr = 1'b1;
                    m.res = 2'b11; m.adr = 1'b1;
                end
                "MEMWB": begin
                    e.res = 2'b01;
                    m.res = 2'b11;
                end
                "EXECR", "EXECI": begin
                    e.src_b = (ph[i] == "EXECI") ? 2'b01 : 2'b00;
                    e.alu   = dec[3:2];
                    m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 2'b11;
                end
                "ALUWB": m.res = 2'b11;
                "BRANCH": begin
                    e.src_b = 2'b01; e.res = 2'b10;
                    m.src_a = 1'b1; m.src_b = 2'b11; m.alu = 2'b11; m.res = 2'b11;
                end
                default: ;
            endcase
            regw = (ph[i] == "MEMWB") || (ph[i] == "ALUWB");
            e.ir = (ph[i] == "FETCH");
            e.pc = (ph[i] == "FETCH") || (((regw && rd == 4'd15) || ph[i] == "BRANCH") && cex);
            e.rw = regw && cex && !nowr;
            e.mw = (ph[i] == "MEMWR") && cex;
            o = {bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc,
                 bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.Flags,
                 bus.ImmSrc, bus.RegSrc};
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("[TB] FAIL %s/%s: got %h required %h (care %h)", tag, ph[i], o & m, e & m, m);
            end
            if ((ph[i] == "EXECR" || ph[i] == "EXECI") && cex) begin
                if (dec[1]) m_flags[3:2] = af[3:2];
                if (dec[0]) m_flags[1:0] = af[1:0];
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0; bus.ALUFlags = 4'b0;
        #1 reset = 1'b0;
        #2;
        n_checks++;
        if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL por_enables: got %b required 0000", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
        end
        n_checks++;
        if (bus.Flags !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL por_flags: got %b required 0000", bus.Flags);
        end
        n_checks++;
        if ({bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc} !== 6'b1_10_10_0) begin
            n_fail++;
            $display("[TB] FAIL por_fetch_selects: got %b required 110100", {bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        m_flags = 4'b0000;
        run_instr("reset_subs", 4'b1110, 2'b00, 6'b000101, 4'd3, 4'b1011);
        // Start an ADD and pull reset partway through its EXECR cycle.
        bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b001000; bus.Rd = 4'd4; bus.ALUFlags = 4'b1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.Flags !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL midexec_flags: got %b required 0000", bus.Flags);
        end
        n_checks++;
        if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL midexec_enables: got %b required 0000", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite});
        end
        n_checks++;
        if ({bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc} !== 6'b1_10_10_0) begin
            n_fail++;
            $display("[TB] FAIL midexec_fetch_selects: got %b required 110100", {bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.AdrSrc});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.Flags} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL held_reset: got %b required 00000000", {bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.Flags});
        end
        reset = 1'b1;
        m_flags = 4'b0000;
    endtask

    task automatic test_adds();
        run_instr("adds", 4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110);
        n_checks++;
        if (bus.Flags !== 4'b0110) begin
            n_fail++;
            $display("[TB] FAIL adds_flags: got %b required 0110", bus.Flags);
        end
    endtask

    task automatic test_cmp_beq();
        run_instr("cmp", 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100);
        n_checks++;
        if (bus.Flags !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL cmp_flags: got %b required 0100", bus.Flags);
        end
        run_instr("beq", 4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
    endtask

    task automatic test_bne();
        run_instr("bne", 4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000);
    endtask

    task automatic test_ldr_str();
        int cycles, mw_cnt;
        for (int k = 0; k < 2; k++) begin
            bus.Cond = 4'b1110; bus.Op = 2'b01; bus.Funct = (k == 0) ? 6'b011001 : 6'b011000;
            bus.Rd = 4'd2; bus.ALUFlags = 4'b0000;
            cycles = 0;
            mw_cnt = 0;
            repeat (12) begin
                @(negedge clk);
                if (cycles > 0 && bus.IRWrite) break;
                cycles++;
                if (bus.MemWrite) mw_cnt++;
                @(posedge clk); #1;
            end
            n_checks++;
            if (cycles != ((k == 0) ? 5 : 4)) begin
                n_fail++;
                $display("[TB] FAIL %s_length: got %0d cycles required %0d", (k == 0) ? "ldr" : "str", cycles, (k == 0) ? 5 : 4);
            end
            n_checks++;
            if (mw_cnt != k) begin
                n_fail++;
                $display("[TB] FAIL %s_memwrite: got %0d cycles required %0d", (k == 0) ? "ldr" : "str", mw_cnt, k);
            end
            // Realign to a FETCH boundary with a two-cycle Op=11 instruction.
            bus.Op = 2'b11;
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_pc_write();
        run_instr("add_pc", 4'b1110, 2'b00, 6'b001000, 4'd15, 4'b0000);
        run_instr("add_pc_nv", 4'b1111, 2'b00, 6'b001000, 4'd15, 4'b0000);
        run_instr("ldr_pc", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_instr("random", 4'($urandom()), 2'($urandom()), 6'($urandom()),
                      ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom()), 4'($urandom()));
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_flags  = 4'b0000;
        test_reset();
        test_adds();
        test_cmp_beq();
        test_bne();
        test_ldr_str();
        test_pc_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
